// File: rtl/jericalla_pkg.sv
// rtl/jericalla_pkg.sv - shared widths and FSM state encoding for the jeric sequencer
package jericalla_pkg;
   localparam int INSTR_W = 17;
   localparam int DATA_W  = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } seq_state_e;
endpackage

// File: rtl/jeric_prog_mem.sv
// rtl/jeric_prog_mem.sv - program buffer, one synchronous write port and one asynchronous read port
module jeric_prog_mem #(
   parameter int DEPTH = 16,
   parameter int W     = 17
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/jeric_sequencer.sv
// rtl/jeric_sequencer.sv - loads a program, issues each word to a datapath and captures its result
// Optional JERIC_SEQ_SKIPZ_EN: a capture with zero flag set skips the following instruction.
module jeric_sequencer import jericalla_pkg::*; #(
   parameter int DEPTH = 16,
   parameter int LAT   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   output logic               load_ready,
   input  logic               clear,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic [INSTR_W-1:0] instr_out,
   output logic               instr_valid,
   input  logic [DATA_W-1:0]  ds_in,
   input  logic               zf_in,
   output logic [DATA_W-1:0]  result_out,
   output logic               zf_out,
   output logic               result_valid
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [3:0]    WAIT_INIT = 4'(LAT - 1);

   seq_state_e         state_q, state_d;
   logic [CW-1:0]      pc_q, pc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [3:0]         wcnt_q, wcnt_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               instr_valid_q, instr_valid_d;
   logic [DATA_W-1:0]  result_q, result_d;
   logic               zf_q, zf_d;
   logic               result_valid_q, result_valid_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;

   logic               mem_we;
   logic [AW-1:0]      rd_addr;
   logic [INSTR_W-1:0] mem_rdata;
   logic [CW-1:0]      pc_step;
   logic [CW-1:0]      pc_adv;

   assign load_ready = (state_q == IDLE) && (cnt_q != DEPTH_C) && !start && !clear;
   assign mem_we     = load_valid && load_ready;

`ifdef JERIC_SEQ_SKIPZ_EN
   assign pc_step = zf_q ? CW'(2) : CW'(1);
`else
   assign pc_step = CW'(1);
`endif

   assign pc_adv = pc_q + pc_step;
   // The word for the next ISSUE is fetched ahead so instr_out can be registered on entry.
   assign rd_addr = (state_q == CAPTURE) ? pc_adv[AW-1:0] : '0;

   jeric_prog_mem #(
      .DEPTH (DEPTH),
      .W     (INSTR_W)
   ) u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (cnt_q[AW-1:0]),
      .wdata (load_data),
      .raddr (rd_addr),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      cnt_d          = cnt_q;
      wcnt_d         = wcnt_q;
      instr_d        = instr_q;
      instr_valid_d  = 1'b0;
      result_d       = result_q;
      zf_d           = zf_q;
      result_valid_d = 1'b0;
      done_d         = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear) begin
               cnt_d = '0;
            end else if (start) begin
               pc_d = '0;
               if (cnt_q == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d       = ISSUE;
                  instr_d       = mem_rdata;
                  instr_valid_d = 1'b1;
               end
            end else if (mem_we) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ISSUE: begin
            state_d = WAIT;
            wcnt_d  = WAIT_INIT;
         end
         WAIT: begin
            if (wcnt_q == '0) begin
               state_d        = CAPTURE;
               result_d       = ds_in;
               zf_d           = zf_in;
               result_valid_d = 1'b1;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         CAPTURE: begin
            pc_d = pc_adv;
            if (pc_adv >= cnt_q) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               state_d       = ISSUE;
               instr_d       = mem_rdata;
               instr_valid_d = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         pc_q           <= '0;
         cnt_q          <= '0;
         wcnt_q         <= '0;
         instr_q        <= '0;
         instr_valid_q  <= 1'b0;
         result_q       <= '0;
         zf_q           <= 1'b0;
         result_valid_q <= 1'b0;
         done_q         <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         cnt_q          <= cnt_d;
         wcnt_q         <= wcnt_d;
         instr_q        <= instr_d;
         instr_valid_q  <= instr_valid_d;
         result_q       <= result_d;
         zf_q           <= zf_d;
         result_valid_q <= result_valid_d;
         done_q         <= done_d;
         busy_q         <= busy_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign instr_out    = instr_q;
   assign instr_valid  = instr_valid_q;
   assign result_out   = result_q;
   assign zf_out       = zf_q;
   assign result_valid = result_valid_q;
endmodule

// File: tb/tb_jeric_sequencer.sv
// tb/tb_jeric_sequencer.sv - directed bench for jeric_sequencer (LAT=1 and LAT=4 instances)
module tb_jeric_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_vec = 0;
   int n_bad = 0;

   // LAT=1 instance
   logic        load_valid, load_ready, clear, start, busy, done;
   logic [16:0] load_data, instr_out;
   logic        instr_valid, zf_in, zf_out, result_valid;
   logic [31:0] ds_in, result_out;
   logic        zf_en;
   logic [16:0] zf_word;

   // Datapath model: result is a fixed function of the issued word.
   assign ds_in = 32'hA5A5_0000 ^ {15'd0, instr_out};
   assign zf_in = zf_en && (instr_out == zf_word);

   jeric_sequencer #(.DEPTH(16), .LAT(1)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .clear(clear), .start(start), .busy(busy), .done(done),
      .instr_out(instr_out), .instr_valid(instr_valid),
      .ds_in(ds_in), .zf_in(zf_in),
      .result_out(result_out), .zf_out(zf_out), .result_valid(result_valid)
   );

   // LAT=4 instance
   logic        b_load_valid, b_load_ready, b_clear, b_start, b_busy, b_done;
   logic [16:0] b_load_data, b_instr_out;
   logic        b_instr_valid, b_zf_out, b_result_valid;
   logic [31:0] b_ds_in, b_result_out;

   assign b_ds_in = 32'hA5A5_0000 ^ {15'd0, b_instr_out};

   jeric_sequencer #(.DEPTH(16), .LAT(4)) dut4 (
      .clk(clk), .rst(rst),
      .load_valid(b_load_valid), .load_data(b_load_data), .load_ready(b_load_ready),
      .clear(b_clear), .start(b_start), .busy(b_busy), .done(b_done),
      .instr_out(b_instr_out), .instr_valid(b_instr_valid),
      .ds_in(b_ds_in), .zf_in(1'b0),
      .result_out(b_result_out), .zf_out(b_zf_out), .result_valid(b_result_valid)
   );

   logic [16:0] iss_w[$];
   int          iss_t[$];
   logic [31:0] cap_d[$];
   logic        cap_z[$];
   int          cap_t[$];
   int          done_t[$];
   int          busy_n;

   logic [16:0] b_iss_w[$];
   int          b_iss_t[$];
   logic [31:0] b_cap_d[$];
   int          b_done_n;

   always @(negedge clk) begin
      if (instr_valid) begin iss_w.push_back(instr_out); iss_t.push_back(cyc); end
      if (result_valid) begin cap_d.push_back(result_out); cap_z.push_back(zf_out); cap_t.push_back(cyc); end
      if (done) done_t.push_back(cyc);
      if (busy) busy_n++;
      if (b_instr_valid) begin b_iss_w.push_back(b_instr_out); b_iss_t.push_back(cyc); end
      if (b_result_valid) b_cap_d.push_back(b_result_out);
      if (b_done) b_done_n++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic clr_log;
      iss_w.delete(); iss_t.delete(); cap_d.delete(); cap_z.delete(); cap_t.delete();
      done_t.delete(); busy_n = 0;
      b_iss_w.delete(); b_iss_t.delete(); b_cap_d.delete(); b_done_n = 0;
   endtask

   task automatic load_word(input logic [16:0] w, output logic rdy);
      load_valid = 1'b1; load_data = w;
      #1 rdy = load_ready;
      step();
      load_valid = 1'b0;
   endtask

   task automatic do_clear;
      clear = 1'b1; step(); clear = 1'b0;
   endtask

   task automatic run(output int t0);
      clr_log();
      t0 = cyc;
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 200 && done_t.size() == 0; i++) step();
      step(); step();
      chk("run_done_count", done_t.size(), 1);
   endtask

   function automatic int first_done();
      return (done_t.size() > 0) ? done_t[0] : -1;
   endfunction

   logic [16:0] a_w [3];
   logic [16:0] s_w [4];
   logic [16:0] b_w [2];
   logic        r;
   int          t0, acc;

   initial begin
      a_w = '{17'h0648D, 17'h0608D, 17'h0628D};
      s_w = '{17'h00011, 17'h00022, 17'h00033, 17'h00044};
      b_w = '{17'h1ABCD, 17'h01234};
      load_valid = 0; load_data = '0; clear = 0; start = 0; zf_en = 0; zf_word = '0;
      b_load_valid = 0; b_load_data = '0; b_clear = 0; b_start = 0;
      clr_log();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();

      chk("rst_instr_out", instr_out, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_result_out", result_out, 0);
      chk("rst_zf_out", zf_out, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_load_ready", load_ready, 1);

      // Three-word program, LAT=1
      for (int i = 0; i < 3; i++) begin
         load_word(a_w[i], r);
         chk("a_load_ready", r, 1);
      end
      run(t0);
      chk("a_issue_count", iss_w.size(), 3);
      chk("a_capture_count", cap_d.size(), 3);
      for (int i = 0; i < 3 && i < iss_w.size(); i++) begin
         chk("a_issue_word", iss_w[i], a_w[i]);
         chk("a_issue_time", iss_t[i], t0 + 1 + 3 * i);
      end
      for (int i = 0; i < 3 && i < cap_d.size(); i++) begin
         chk("a_capture_data", cap_d[i], 32'hA5A5_0000 ^ {15'd0, a_w[i]});
         chk("a_capture_zf", cap_z[i], 0);
         chk("a_capture_time", cap_t[i], t0 + 3 + 3 * i);
      end
      chk("a_done_time", first_done(), t0 + 10);
      chk("a_instr_hold", instr_out, a_w[2]);
      chk("a_result_hold", result_out, 32'hA5A5_0000 ^ {15'd0, a_w[2]});
      chk("a_busy_after", busy, 0);

      // Re-run uses retained buffer
      run(t0);
      chk("rerun_count", iss_w.size(), 3);
      if (iss_w.size() > 0) chk("rerun_first", iss_w[0], a_w[0]);

      // Empty buffer
      do_clear();
      run(t0);
      chk("empty_issue_count", iss_w.size(), 0);
      chk("empty_done_time", first_done(), t0 + 1);
      chk("empty_busy_cycles", busy_n, 1);

      // Fill to DEPTH, then one more offer
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         load_word(17'h10000 | 17'(i), r);
         if (r) acc++;
      end
      chk("full_accepted", acc, 16);
      load_word(17'h1FFFF, r);
      chk("full_load_ready", r, 0);
      run(t0);
      chk("full_issue_count", iss_w.size(), 16);
      if (iss_w.size() > 0) chk("full_last_word", iss_w[iss_w.size() - 1], 17'h1000F);
      chk("full_done_time", first_done(), t0 + 16 * 3 + 1);

      // Zero flag on the first word
      do_clear();
      for (int i = 0; i < 4; i++) load_word(s_w[i], r);
      zf_word = s_w[0]; zf_en = 1'b1;
      run(t0);
      zf_en = 1'b0;
      if (cap_z.size() > 1) begin
         chk("zf_first_capture", cap_z[0], 1);
         chk("zf_second_capture", cap_z[1], 0);
      end
`ifdef JERIC_SEQ_SKIPZ_EN
      chk("skip_issue_count", iss_w.size(), 3);
      if (iss_w.size() == 3) begin
         chk("skip_word0", iss_w[0], s_w[0]);
         chk("skip_word1", iss_w[1], s_w[2]);
         chk("skip_word2", iss_w[2], s_w[3]);
      end
`else
      chk("noskip_issue_count", iss_w.size(), 4);
      for (int i = 0; i < 4 && i < iss_w.size(); i++) chk("noskip_word", iss_w[i], s_w[i]);
`endif

      // Reset during the second WAIT
      do_clear();
      for (int i = 0; i < 3; i++) load_word(a_w[i], r);
      clr_log();
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 20 && iss_w.size() < 2; i++) step();
      chk("mid_second_issue", iss_w.size(), 2);
      step();
      rst = 1'b1;
      #1;
      chk("mid_rst_instr_out", instr_out, 0);
      chk("mid_rst_instr_valid", instr_valid, 0);
      chk("mid_rst_result_out", result_out, 0);
      chk("mid_rst_result_valid", result_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      step();
      rst = 1'b0;
      repeat (6) step();
      chk("mid_no_done", done_t.size(), 0);
      for (int i = 0; i < 3; i++) load_word(a_w[i], r);
      run(t0);
      chk("mid_rerun_count", iss_w.size(), 3);
      if (iss_w.size() > 0) chk("mid_rerun_first", iss_w[0], a_w[0]);

      // LAT=4 instance, inputs toggled while busy
      for (int i = 0; i < 2; i++) begin
         b_load_valid = 1'b1; b_load_data = b_w[i]; step();
      end
      b_load_valid = 1'b0;
      clr_log();
      t0 = cyc;
      b_start = 1'b1; step();
      b_load_valid = 1'b1; b_load_data = 17'h15555; b_clear = 1'b1;
      #1;
      chk("b_busy_mid", b_busy, 1);
      chk("b_load_ready_busy", b_load_ready, 0);
      repeat (5) step();
      b_load_valid = 1'b0; b_clear = 1'b0; b_start = 1'b0;
      for (int i = 0; i < 50 && b_done_n == 0; i++) step();
      step();
      chk("b_done_count", b_done_n, 1);
      chk("b_issue_count", b_iss_w.size(), 2);
      if (b_iss_t.size() == 2) begin
         chk("b_issue_time0", b_iss_t[0], t0 + 1);
         chk("b_issue_spacing", b_iss_t[1] - b_iss_t[0], 6);
         chk("b_issue_word1", b_iss_w[1], b_w[1]);
      end
      if (b_cap_d.size() == 2) chk("b_capture1", b_cap_d[1], 32'hA5A5_0000 ^ {15'd0, b_w[1]});
      clr_log();
      b_start = 1'b1; step(); b_start = 1'b0;
      for (int i = 0; i < 50 && b_done_n == 0; i++) step();
      step();
      chk("b_rerun_count", b_iss_w.size(), 2);
      if (b_iss_w.size() == 2) chk("b_rerun_word0", b_iss_w[0], b_w[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
